game_sequencer: RTL
===================

Name: game_sequencer

Overview:
Central single-clock controller for the whack-a-mole game. It sequences the game through IDLE, a pre-game countdown, the timed play window and game-over, and qualifies debounced button presses against the lit mole LEDs to keep score. Its outputs drive the display multiplexer select, the countdown and score display paths, and the mole-pattern generator enable. Timing is derived from a one-cycle 1 Hz tick enable, not from a divided clock.

Parameters:
COUNTDOWN_SEC, 5, pre-game countdown length in seconds (1..15)
GAME_SEC, 30, play window length in seconds (1..63)
SCORE_W, 8, score register width

Ports:
clk  in  1  system clock (100 MHz)
reset  in  1  synchronous, active-high reset
tick_1hz  in  1  one-clk pulse, once per second
start  in  1  debounced start button, level
button_db  in  5  debounced mole buttons, level
mole_led  in  5  current mole pattern (one-hot or zero)
mole_enable  out  1  high only in PLAY; gates mole pattern generator
game_begin  out  1  high in PLAY and OVER; display mux selects score
countdown_val  out  4  seconds remaining in COUNTDOWN
time_left  out  6  seconds remaining in PLAY
score  out  SCORE_W  hits this game, binary
hit_pulse  out  1  one-clk pulse per accepted hit
miss_pulse  out  1  one-clk pulse per wrong-button press
game_over  out  1  high in OVER
state  out  2  IDLE=0, COUNTDOWN=1, PLAY=2, OVER=3

Behaviour:
- All outputs registered; response appears one clk after the causing input cycle.
- Reset (any state, mid-game included): state=IDLE, countdown_val=0, time_left=0, score=0, lockout=0, all pulses 0, mole_enable=game_begin=game_over=0, edge-detect history=0.
- start and button_db edge-detected internally: rise = cur & ~prev; prev updates every clk in every state.
- IDLE: start rise -> COUNTDOWN, countdown_val=COUNTDOWN_SEC, score=0.
- COUNTDOWN: tick decrements countdown_val; tick with countdown_val==1 -> PLAY, countdown_val=0, time_left=GAME_SEC, lockout=0. Buttons and start are ignored.
- PLAY: tick decrements time_left; tick with time_left==1 -> OVER, time_left=0. start is ignored.
- OVER: score and time_left held; start rise -> COUNTDOWN (score cleared, as from IDLE).
- Hit evaluation, PLAY only: hit = |(rise & mole_led) & ~lockout. On hit: score+1 (saturates at all-ones), hit_pulse=1, lockout=1.
- miss = |(rise & ~mole_led); miss_pulse=1, no score change. Hit and miss may pulse in the same clk.
- tick clears lockout. Hit and tick in the same clk: the hit counts and lockout ends at 0.
- Hit on the final tick of PLAY counts; the next state is still OVER.
- A button already held when PLAY is entered produces no rise and does not score.
- mole_led==0 means no hit is possible; any press is a miss.
- Illegal state encodings recover to IDLE on the next clk.

Decomposition:
- Package game_pkg: state encoding constants, default COUNTDOWN_SEC/GAME_SEC, state width.
- One sub-module: rise_detect (parameterised width, registered prev, rise = cur & ~prev), instantiated for start (width 1) and buttons (width 5).
- FSM, timers and score stay in game_sequencer.

Test Plan:
- Reset, then start pulse -> state=1, countdown_val=5. After 5 ticks: state=2, time_left=30, mole_enable=1, game_begin=1.
- In PLAY, mole_led=00100, press button 2 -> score 0->1, one hit_pulse. Press again before the next tick -> no change. Press after the next tick -> score=2.
- mole_led=00100, press button 0 -> miss_pulse=1, score unchanged. Press buttons 0 and 2 together -> hit_pulse and miss_pulse both 1, score+1.
- Run 30 ticks in PLAY with a hit in the clk of the 30th tick -> score includes that hit. state=3, game_over=1, time_left=0, score then held.
- Assert reset mid-PLAY with score=7 -> next clk: state=0, score=0, mole_enable=0. Start pressed during COUNTDOWN -> ignored. Start in OVER -> COUNTDOWN, score=0.
- Hold button 1 through the COUNTDOWN->PLAY transition with mole_led=00010 -> no hit. Release and re-press -> hit.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared definitions for the whack-a-mole game controller.
// Contents: state encoding (IDLE/COUNTDOWN/PLAY/OVER), state width and
// default countdown / play-window lengths in seconds.
package game_pkg;

  localparam int unsigned STATE_W           = 2;
  localparam int unsigned COUNTDOWN_SEC_DEF = 5;
  localparam int unsigned GAME_SEC_DEF      = 30;
  localparam int unsigned NUM_MOLES         = 5;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 2'd0,
    COUNTDOWN = 2'd1,
    PLAY      = 2'd2,
    OVER      = 2'd3
  } state_t;

endpackage

// File: rtl/game_sequencer_rise_detect.sv
// rise_detect: registered rising-edge detector for a bus of level inputs.
// Ports:
//   clk   - system clock
//   reset - synchronous active-high reset, clears the history register
//   cur   - current level of the inputs
//   rise  - per-bit rising edge, cur & ~prev (combinational from cur)
module rise_detect #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk) begin
    if (reset) prev <= '0;
    else       prev <= cur;
  end

  assign rise = cur & ~prev;

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: central controller for the whack-a-mole game.
// Sequences IDLE -> COUNTDOWN -> PLAY -> OVER using a one-cycle 1 Hz tick
// enable, and scores edge-detected button presses against the lit moles.
// Ports:
//   clk, reset     - system clock, synchronous active-high reset
//   tick_1hz       - one-clk pulse per second
//   start          - debounced start button (level)
//   button_db      - debounced mole buttons (level)
//   mole_led       - current mole pattern (one-hot or zero)
//   mole_enable    - high in PLAY, gates the mole pattern generator
//   game_begin     - high in PLAY and OVER, display shows score
//   countdown_val  - seconds remaining in COUNTDOWN
//   time_left      - seconds remaining in PLAY
//   score          - hits this game, saturating
//   hit_pulse      - one-clk pulse per accepted hit
//   miss_pulse     - one-clk pulse per wrong-button press
//   game_over      - high in OVER
//   state          - current state encoding
module game_sequencer
  import game_pkg::*;
#(
  parameter int unsigned COUNTDOWN_SEC = COUNTDOWN_SEC_DEF,
  parameter int unsigned GAME_SEC      = GAME_SEC_DEF,
  parameter int unsigned SCORE_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick_1hz,
  input  logic               start,
  input  logic [4:0]         button_db,
  input  logic [4:0]         mole_led,
  output logic               mole_enable,
  output logic               game_begin,
  output logic [3:0]         countdown_val,
  output logic [5:0]         time_left,
  output logic [SCORE_W-1:0] score,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic               game_over,
  output logic [STATE_W-1:0] state
);

  localparam logic [3:0] CD_INIT   = 4'(COUNTDOWN_SEC);
  localparam logic [5:0] GAME_INIT = 6'(GAME_SEC);

  state_t     st_q;
  logic       lockout;
  logic       start_rise;
  logic [4:0] btn_rise;
  logic       hit;
  logic       miss;

  rise_detect #(.WIDTH(1)) u_start_rise (
    .clk   (clk),
    .reset (reset),
    .cur   (start),
    .rise  (start_rise)
  );

  rise_detect #(.WIDTH(NUM_MOLES)) u_btn_rise (
    .clk   (clk),
    .reset (reset),
    .cur   (button_db),
    .rise  (btn_rise)
  );

  // Lockout allows at most one scored hit per second.
  assign hit  = (|(btn_rise & mole_led)) & ~lockout;
  assign miss = |(btn_rise & ~mole_led);

  assign state = st_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q          <= IDLE;
      countdown_val <= '0;
      time_left     <= '0;
      score         <= '0;
      lockout       <= 1'b0;
      hit_pulse     <= 1'b0;
      miss_pulse    <= 1'b0;
      mole_enable   <= 1'b0;
      game_begin    <= 1'b0;
      game_over     <= 1'b0;
    end else begin
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      case (st_q)
        IDLE, OVER: begin
          if (start_rise) begin
            st_q          <= COUNTDOWN;
            countdown_val <= CD_INIT;
            score         <= '0;
            game_begin    <= 1'b0;
            game_over     <= 1'b0;
          end
        end
        COUNTDOWN: begin
          if (tick_1hz) begin
            if (countdown_val == 4'd1) begin
              st_q          <= PLAY;
              countdown_val <= '0;
              time_left     <= GAME_INIT;
              lockout       <= 1'b0;
              mole_enable   <= 1'b1;
              game_begin    <= 1'b1;
            end else begin
              countdown_val <= countdown_val - 4'd1;
            end
          end
        end
        PLAY: begin
          if (hit) begin
            hit_pulse <= 1'b1;
            if (score != '1) score <= score + SCORE_W'(1);
          end
          miss_pulse <= miss;
          // A tick wins over a same-cycle hit for lockout; the hit still scores.
          if (tick_1hz) begin
            lockout <= 1'b0;
            if (time_left == 6'd1) begin
              st_q        <= OVER;
              time_left   <= '0;
              mole_enable <= 1'b0;
              game_over   <= 1'b1;
            end else begin
              time_left <= time_left - 6'd1;
            end
          end else if (hit) begin
            lockout <= 1'b1;
          end
        end
        default: begin
          st_q          <= IDLE;
          countdown_val <= '0;
          time_left     <= '0;
          score         <= '0;
          lockout       <= 1'b0;
          mole_enable   <= 1'b0;
          game_begin    <= 1'b0;
          game_over     <= 1'b0;
        end
      endcase
    end
  end

endmodule
